iq_frame_packer: RTL and testbench

IQ_FRAME_PACKER -- requirements
Module: iq_frame_packer

---
 rtl/iq_frame_packer_pkg.sv | 16 +
 rtl/iq_frame_packer_fifo.sv | 51 +++++
 rtl/iq_frame_packer.sv | 153 +++++++++++++++
 tb/tb_iq_frame_packer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_frame_packer_pkg.sv
// Shared constants and types for the IQ frame packer: sync word, FSM state
// encoding and header field positions.
package iq_frame_packer_pkg;

  localparam logic [15:0] SYNC_WORD = 16'hA5C3;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_HEADER  = 2'd1;
  localparam state_t ST_PAYLOAD = 2'd2;

  localparam int unsigned HDR_SYNC_LSB = 16;
  localparam int unsigned HDR_SEQ_LSB  = 8;
  localparam int unsigned HDR_LEN_LSB  = 0;

endpackage

// File: rtl/iq_frame_packer_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; pointers wrap modulo DEPTH.
module iq_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_wr_en, i_rd_en})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_level   = r_level;

endmodule

// File: rtl/iq_frame_packer.sv
// Packs truncated I/Q samples into 32-bit words and emits them as framed
// bursts (sync/seq/len header followed by payload), with flush for partial frames.
module iq_frame_packer
  import iq_frame_packer_pkg::*;
#(
  parameter int unsigned OUTPUT_WIDTH = 18,
  parameter int unsigned FRAME_LEN    = 16,
  parameter int unsigned FIFO_DEPTH   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [OUTPUT_WIDTH-1:0]       i_data,
  input  logic [OUTPUT_WIDTH-1:0]       q_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          enable,
  input  logic                          flush,
  output logic [31:0]                   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic [15:0]                   frames_sent,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  state_t        r_state;
  logic [7:0]    r_len;
  logic [7:0]    r_cnt;
  logic [7:0]    r_seq;
  logic [15:0]   r_frames;
  logic          r_flush_pend;

  logic          w_accept;
  logic          w_pop;
  logic          w_full_start;
  logic          w_flush_start;
  logic          w_last;
  logic [31:0]   w_wr_word;
  logic [31:0]   w_head;
  logic [31:0]   w_hdr;
  logic [LW-1:0] w_level;

  assign w_wr_word = {i_data[OUTPUT_WIDTH-1 -: 16], q_data[OUTPUT_WIDTH-1 -: 16]};

  if (OUTPUT_WIDTH > 16) begin : g_trunc
    logic w_unused;
    assign w_unused = ^{i_data[OUTPUT_WIDTH-17:0], q_data[OUTPUT_WIDTH-17:0]};
  end

  // rst_n gates in_ready so it reads low throughout reset
  assign in_ready      = rst_n & enable & (w_level < LW'(FIFO_DEPTH));
  assign w_accept      = in_valid & in_ready;
  assign w_pop         = (r_state == ST_PAYLOAD) & m_ready;
  assign w_full_start  = (r_state == ST_IDLE) & (w_level >= LW'(FRAME_LEN));
  assign w_flush_start = (r_state == ST_IDLE) & ~w_full_start & r_flush_pend & (w_level != '0);
  assign w_last        = (r_state == ST_PAYLOAD) & (r_cnt == (r_len - 8'd1));

  iq_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_accept),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_level   (w_level)
  );

  always_comb begin
    w_hdr = '0;
    w_hdr[HDR_SYNC_LSB +: 16] = SYNC_WORD;
    w_hdr[HDR_SEQ_LSB  +: 8]  = r_seq;
    w_hdr[HDR_LEN_LSB  +: 8]  = r_len;
  end

  always_comb begin
    m_data  = '0;
    m_valid = 1'b0;
    case (r_state)
      ST_HEADER: begin
        m_data  = w_hdr;
        m_valid = 1'b1;
      end
      ST_PAYLOAD: begin
        m_data  = w_head;
        m_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign m_last      = w_last;
  assign frames_sent = r_frames;
  assign fifo_level  = w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_len    <= '0;
      r_cnt    <= '0;
      r_seq    <= '0;
      r_frames <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_full_start) begin
            r_state <= ST_HEADER;
            r_len   <= 8'(FRAME_LEN);
          end else if (w_flush_start) begin
            r_state <= ST_HEADER;
            r_len   <= 8'(w_level);
          end
        end
        ST_HEADER: begin
          if (m_ready) begin
            r_state <= ST_PAYLOAD;
            r_cnt   <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (m_ready) begin
            if (w_last) begin
              r_state  <= ST_IDLE;
              r_seq    <= r_seq + 8'd1;
              r_frames <= r_frames + 16'd1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A full frame started while a flush is pending leaves the flush armed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pend <= 1'b0;
    end else if (flush) begin
      r_flush_pend <= 1'b1;
    end else if (w_flush_start) begin
      r_flush_pend <= 1'b0;
    end else if ((r_state == ST_IDLE) && (w_level == '0)) begin
      r_flush_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iq_frame_packer.sv
// Directed-plus-random bench for iq_frame_packer against a queue-based frame model.
module tb_iq_frame_packer;

  localparam int OW = 18;
  localparam int FL = 16;
  localparam int FD = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [OW-1:0] i_data = '0;
  logic [OW-1:0] q_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          enable = 1'b1;
  logic          flush = 1'b0;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic [15:0]   frames_sent;
  logic [5:0]    fifo_level;

  iq_frame_packer #(
    .OUTPUT_WIDTH (OW),
    .FRAME_LEN    (FL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_data      (i_data),
    .q_data      (q_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .enable      (enable),
    .flush       (flush),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .frames_sent (frames_sent),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered words, words left in the current frame, seq, frame count
  logic [31:0] sq[$];
  int          rem = 0;
  int          mseq = 0;
  int          mframes = 0;
  logic        toggle_mr = 1'b0;
  logic        fixed_sample = 1'b0;
  logic        last_acc = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [31:0] last_hdr = '0;
  logic [31:0] last_payload = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [OW-1:0] i, input logic [OW-1:0] q);
    logic [31:0] ih, qh;
    ih = 32'(i) / 4;
    qh = 32'(q) / 4;
    return ih * 65536 + qh;
  endfunction

  task automatic new_sample();
    if (!fixed_sample) begin
      i_data = OW'($urandom);
      q_data = OW'($urandom);
    end
  endtask

  // One clock: check outputs against the model, then advance the model on the edge
  task automatic cycle();
    logic        acc, hs;
    int          len;
    logic [31:0] exp;
    if (toggle_mr) m_ready = ~m_ready;
    #1;
    chk("in_ready", 32'(in_ready), 32'(enable && (sq.size() < FD)));
    chk("fifo_level", 32'(fifo_level), 32'(sq.size()));
    chk("frames_sent", 32'(frames_sent), 32'(mframes % 65536));
    if (prev_stall) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", m_data, prev_data);
      chk("hold_last", 32'(m_last), 32'(prev_last));
    end
    acc = in_valid && enable && (sq.size() < FD);
    hs  = m_valid && m_ready;
    if (hs) begin
      if (rem == 0) begin
        len = (sq.size() >= FL) ? FL : sq.size();
        exp = {16'hA5C3, 8'(mseq), 8'(len)};
        chk("header", m_data, exp);
        chk("header_last", 32'(m_last), 32'd0);
        last_hdr = m_data;
        rem = len;
      end else begin
        exp = sq.pop_front();
        chk("payload", m_data, exp);
        chk("payload_last", 32'(m_last), 32'(rem == 1));
        last_payload = m_data;
        rem--;
        if (rem == 0) begin
          mseq = (mseq + 1) % 256;
          mframes++;
        end
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    @(posedge clk);
    if (acc) sq.push_back(pack(i_data, q_data));
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic send(input int n);
    int sent = 0;
    int guard = 0;
    in_valid = 1'b1;
    new_sample();
    while (sent < n && guard < 2000) begin
      cycle();
      if (last_acc) begin
        sent++;
        new_sample();
      end
      guard++;
    end
    in_valid = 1'b0;
    if (sent < n) chk("send_timeout", 32'(sent), 32'(n));
  endtask

  task automatic drain(input int budget);
    int g = 0;
    while ((sq.size() > 0 || rem > 0) && g < budget) begin
      cycle();
      g++;
    end
    if (sq.size() > 0 || rem > 0) chk("drain_timeout", 32'(sq.size() + rem), 32'd0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    int g;
    logic [5:0] lvl_before;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_frames", 32'(frames_sent), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame with fixed samples, plus minimum header latency
    m_ready = 1'b1;
    fixed_sample = 1'b1;
    i_data = 18'h1FFFC;
    q_data = 18'h00004;
    send(FL);
    #1 chk("latency_idle", 32'(m_valid), 32'd0);
    cycle();
    #1;
    chk("latency_hdr_valid", 32'(m_valid), 32'd1);
    chk("latency_hdr_data", m_data, 32'hA5C3_0010);
    drain(200);
    chk("full_hdr", last_hdr, 32'hA5C3_0010);
    chk("full_payload", last_payload, 32'h7FFF_0001);
    chk("full_frames", 32'(frames_sent), 32'd1);
    fixed_sample = 1'b0;

    // Flush of a 5-sample partial frame
    send(5);
    pulse_flush();
    drain(200);
    chk("flush_hdr_sync", 32'(last_hdr[31:16]), 32'h0000_A5C3);
    chk("flush_hdr_len", 32'(last_hdr[7:0]), 32'd5);
    chk("flush_frames", 32'(frames_sent), 32'd2);

    // Backpressure: fill to capacity, then toggle m_ready
    m_ready = 1'b0;
    send(FD);
    in_valid = 1'b1;
    new_sample();
    cycle();
    chk("full_blocks_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    toggle_mr = 1'b1;
    send(8);
    g = 0;
    while ((sq.size() > 8 || rem > 0) && g < 500) begin
      cycle();
      g++;
    end
    chk("bp_residue", 32'(sq.size()), 32'd8);
    toggle_mr = 1'b0;
    m_ready = 1'b1;
    pulse_flush();
    drain(200);
    chk("bp_frames", 32'(frames_sent), 32'd5);

    // Empty flush produces nothing
    pulse_flush();
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("empty_flush_idle", 32'(m_valid), 32'd0);
    end

    // Accept and pop in the same cycle keep the level
    send(FL);
    g = 0;
    while (rem == 0 && g < 100) begin
      cycle();
      g++;
    end
    lvl_before = fifo_level;
    in_valid = 1'b1;
    new_sample();
    cycle();
    in_valid = 1'b0;
    chk("acc_pop_level", 32'(fifo_level), 32'(lvl_before));
    g = 0;
    while (rem > 0 && g < 200) begin
      cycle();
      g++;
    end
    pulse_flush();
    drain(200);

    // Reset after the third payload word
    send(FL);
    g = 0;
    while (rem != FL - 3 && g < 200) begin
      cycle();
      g++;
    end
    chk("mid_payload_reached", 32'(rem), 32'(FL - 3));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(m_valid), 32'd0);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    sq.delete();
    rem = 0;
    mseq = 0;
    mframes = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 257 frames from reset: seq wraps back to 0
    for (int f = 1; f <= 257; f++) begin
      send(FL);
      drain(200);
      if (f == 1) chk("post_reset_seq", 32'(last_hdr[15:8]), 32'd0);
    end
    chk("wrap_seq", 32'(last_hdr[15:8]), 32'd0);
    chk("wrap_frames", 32'(frames_sent), 32'd257);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
